// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserialiser with selectable bit order, shift enable,
// frame resync, a one-word valid/ready holding register and a sticky overrun flag.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_serial_in,
    input  logic             i_shift_en,
    input  logic             i_frame_start,
    input  logic             i_clr_overrun,
    output logic [WIDTH-1:0] o_parallel_out,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [CNT_W-1:0] o_bit_count,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_parallel;
    logic             r_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_shift_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_complete;
    logic             w_load;
    logic             w_drop;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // Next shift register / bit counter; resync takes precedence and can never complete a word.
    always_comb begin
        w_shift_nxt = r_shift;
        w_count_nxt = r_count;
        w_complete  = 1'b0;
        if (i_frame_start) begin
            if (i_shift_en) begin
                // The resync bit is the first bit of the new word.
                w_shift_nxt = MSB_FIRST ? {{(WIDTH-1){1'b0}}, i_serial_in}
                                        : {i_serial_in, {(WIDTH-1){1'b0}}};
                w_count_nxt = CNT_W'(1);
            end else begin
                w_shift_nxt = '0;
                w_count_nxt = '0;
            end
        end else if (i_shift_en) begin
            w_shift_nxt = MSB_FIRST ? {r_shift[WIDTH-2:0], i_serial_in}
                                    : {i_serial_in, r_shift[WIDTH-1:1]};
            if (r_count == LAST_BIT) begin
                w_complete  = 1'b1;
                w_count_nxt = '0;
            end else begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end
    end

    // A completed word loads if the holding register is free or being accepted this edge.
    always_comb begin
        w_load = w_complete && (!r_valid || i_out_ready);
        w_drop = w_complete && r_valid && !i_out_ready;
    end

    // Shift register and bit counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shift <= '0;
            r_count <= '0;
        end else begin
            r_shift <= w_shift_nxt;
            r_count <= w_count_nxt;
        end
    end

    // Holding register with valid/ready handshake; the word goes straight from the shifter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_parallel <= '0;
            r_valid    <= 1'b0;
        end else if (w_load) begin
            r_parallel <= w_shift_nxt;
            r_valid    <= 1'b1;
        end else if (!w_complete && r_valid && i_out_ready) begin
            r_valid    <= 1'b0;
        end
    end

    // Sticky overrun; a drop on the same edge as a clear wins.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign o_parallel_out = r_parallel;
    assign o_out_valid    = r_valid;
    assign o_bit_count    = r_count;
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: one MSB-first and one LSB-first instance share stimulus;
// a bit-queue reference model feeds a scoreboard drained by a handshake monitor.
module tb_sipo_deser;
    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic clk = 1'b0;
    logic reset, serial, shift_en, frame_start, clr_ovr, out_ready;
    logic [W-1:0]  pout_m, pout_l;
    logic          valid_m, valid_l, ovr_m, ovr_l;
    logic [CW-1:0] cnt_m, cnt_l;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(clk), .i_reset(reset), .i_serial_in(serial), .i_shift_en(shift_en),
        .i_frame_start(frame_start), .i_clr_overrun(clr_ovr), .o_parallel_out(pout_m),
        .o_out_valid(valid_m), .i_out_ready(out_ready), .o_bit_count(cnt_m),
        .o_overrun(ovr_m));

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(clk), .i_reset(reset), .i_serial_in(serial), .i_shift_en(shift_en),
        .i_frame_start(frame_start), .i_clr_overrun(clr_ovr), .o_parallel_out(pout_l),
        .o_out_valid(valid_l), .i_out_ready(out_ready), .o_bit_count(cnt_l),
        .o_overrun(ovr_l));

    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] l;
    } word_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    word_t sbq[$];
    bit    bits[$];
    bit    m_valid = 1'b0;
    bit    m_ovr   = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word from arrival order: arrival i lands at W-1-i (MSB-first) or at i (LSB-first).
    function automatic word_t assemble();
        word_t w;
        w.m = '0;
        w.l = '0;
        for (int i = 0; i < W; i++) begin
            w.m[W-1-i] = bits[i];
            w.l[i]     = bits[i];
        end
        return w;
    endfunction

    task automatic model_edge();
        bit    complete = 1'b0;
        bit    drop;
        word_t w;
        w.m = '0;
        w.l = '0;
        if (frame_start) begin
            bits.delete();
            if (shift_en) bits.push_back(serial);
        end else if (shift_en) begin
            bits.push_back(serial);
            if (bits.size() == W) begin
                complete = 1'b1;
                w = assemble();
                bits.delete();
            end
        end
        drop = complete && m_valid && !out_ready;
        if (complete && (!m_valid || out_ready)) begin
            sbq.push_back(w);
            m_valid = 1'b1;
        end else if (!complete && m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
    endtask

    task automatic check_state();
        chk("valid_msb", valid_m, m_valid);
        chk("valid_lsb", valid_l, m_valid);
        chk("count_msb", cnt_m, bits.size());
        chk("count_lsb", cnt_l, bits.size());
        chk("overrun_msb", ovr_m, m_ovr);
        chk("overrun_lsb", ovr_l, m_ovr);
    endtask

    task automatic step(bit s_en, bit sin, bit fs = 1'b0, bit rdy = 1'b1, bit clr = 1'b0);
        shift_en    = s_en;
        serial      = sin;
        frame_start = fs;
        out_ready   = rdy;
        clr_ovr     = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_state();
    endtask

    task automatic send_msb(logic [7:0] b, bit rdy);
        for (int i = 7; i >= 0; i--) step(1'b1, b[i], 1'b0, rdy);
    endtask

    // Monitor: whenever a word is presented and accepted, compare against the scoreboard.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            if (!reset && valid_m && out_ready) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: got word %0h expected none", pout_m);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_word_msb", pout_m, e.m);
                    chk("sb_word_lsb", pout_l, e.l);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b1, b2;
        reset = 1'b1; serial = 1'b0; shift_en = 1'b0; frame_start = 1'b0;
        clr_ovr = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_pout", pout_m, 0);
        chk("rst_valid", valid_m, 0);
        chk("rst_count", cnt_m, 0);
        chk("rst_ovr", ovr_m, 0);
        #11 reset = 1'b0;

        // 1: MSB-first A5
        b1 = 8'hA5;
        for (int i = 7; i >= 0; i--) step(1'b1, b1[i]);
        chk("t1_word", pout_m, 8'hA5);
        chk("t1_valid", valid_m, 1);
        chk("t1_count", cnt_m, 0);

        // 2: LSB-first 2D with two idle cycles between bits
        b1 = 8'b0010_1101;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, b1[i]);
            if (i != 7) begin
                step(1'b0, 1'b0);
                step(1'b0, 1'b1);
            end
        end
        chk("t2_word_lsb", pout_l, 8'h2D);

        // 3: overrun with out_ready low, then clear
        step(1'b0, 1'b0);
        send_msb(8'hA5, 1'b0);
        send_msb(8'h3C, 1'b0);
        chk("t3_word_kept", pout_m, 8'hA5);
        chk("t3_ovr_set", ovr_m, 1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_ovr_clr", ovr_m, 0);
        step(1'b0, 1'b0);

        // 4: back-to-back stream with out_ready held
        send_msb(8'h11, 1'b1);
        chk("t4_word1", pout_m, 8'h11);
        send_msb(8'h22, 1'b1);
        chk("t4_word2", pout_m, 8'h22);
        chk("t4_ovr", ovr_m, 0);

        // 5: resync after 5 bits
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("t5_count_fs", cnt_m, 1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        chk("t5_word", pout_m, 8'h80);
        chk("t5_word_lsb", pout_l, 8'h01);

        // 6: async reset mid-word
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        #2 reset = 1'b1;
        #1;
        bits.delete(); sbq.delete(); m_valid = 1'b0; m_ovr = 1'b0;
        chk("t6_pout", pout_m, 0);
        chk("t6_valid", valid_m, 0);
        chk("t6_count", cnt_m, 0);
        chk("t6_ovr", ovr_m, 0);
        #1 reset = 1'b0;
        send_msb(8'h5A, 1'b1);
        chk("t6_fresh", pout_m, 8'h5A);

        // Randomised traffic
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 9) < 7), $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) < 5));
        end
        b2 = 8'h00;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("sb_drained", sbq.size(), b2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
